// File: rtl/traffic_generator_gmii_if.sv
// Control/status and GMII transmit bundle for traffic_generator_gmii.
// master = generator side, slave = controller/observer side.
interface traffic_generator_gmii_if;
  logic        enable;
  logic [15:0] frame_size;
  logic [15:0] ifg;
  logic [31:0] frame_count;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [7:0]  gmii_d;
  logic        gmii_en;
  logic        gmii_er;
  logic        busy;
  logic [31:0] pkts_sent;
  logic [63:0] octets_sent;

  modport master (
    input  enable, frame_size, ifg, frame_count, dst_mac, src_mac, ethertype,
    output gmii_d, gmii_en, gmii_er, busy, pkts_sent, octets_sent
  );

  modport slave (
    output enable, frame_size, ifg, frame_count, dst_mac, src_mac, ethertype,
    input  gmii_d, gmii_en, gmii_er, busy, pkts_sent, octets_sent
  );
endinterface

// File: rtl/traffic_generator_gmii.sv
// Ethernet frame generator on GMII: preamble, SFD, fixed header, counting
// payload, CRC32 FCS and a programmable inter-frame gap.
module traffic_generator_gmii #(
  parameter int unsigned C_MIN_IFG   = 12,
  parameter int unsigned C_MAX_FRAME = 1518
) (
  input  logic                     clk,
  input  logic                     resetn,
  traffic_generator_gmii_if.master bus
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, GAP} state_t;

  state_t       state, state_n;
  logic [15:0]  cnt, cnt_n;
  logic [15:0]  pay_len, ifg_len;
  logic [15:0]  eff_size, eff_ifg;
  logic [111:0] hdr;
  logic [31:0]  crc;
  logic [31:0]  run_cnt, frame_lim;
  logic         armed;
  logic         start, run_start, run_done;
  logic [7:0]   d_n;
  logic         en_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    eff_size = bus.frame_size;
    if (bus.frame_size < 16'd64)
      eff_size = 16'd64;
    else if (bus.frame_size > 16'(C_MAX_FRAME))
      eff_size = 16'(C_MAX_FRAME);
    eff_ifg = (bus.ifg < 16'(C_MIN_IFG)) ? 16'(C_MIN_IFG) : bus.ifg;
  end

  assign run_done = (frame_lim != '0) && (run_cnt == frame_lim);

  // Outputs are registered from the next state, so the octet for a state
  // appears on the wire in the same cycle the state register holds it.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    start     = 1'b0;
    run_start = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.enable && armed) begin
          state_n   = PREAMBLE;
          start     = 1'b1;
          run_start = 1'b1;
        end
      end
      PREAMBLE: if (cnt == 16'd6) begin state_n = SFD; cnt_n = '0; end
      SFD:      begin state_n = HEADER; cnt_n = '0; end
      HEADER:   if (cnt == 16'd13) begin state_n = PAYLOAD; cnt_n = '0; end
      PAYLOAD:  if (cnt == pay_len - 16'd1) begin state_n = FCS; cnt_n = '0; end
      FCS:      if (cnt == 16'd3) begin state_n = GAP; cnt_n = '0; end
      GAP: begin
        if (cnt == ifg_len - 16'd1) begin
          cnt_n = '0;
          if (bus.enable && !run_done) begin
            state_n = PREAMBLE;
            start   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin state_n = IDLE; cnt_n = '0; end
    endcase

    d_n  = '0;
    en_n = 1'b1;
    unique case (state_n)
      PREAMBLE: d_n = 8'h55;
      SFD:      d_n = 8'hD5;
      HEADER:   d_n = hdr[111:104];
      PAYLOAD:  d_n = cnt_n[7:0];
      FCS:      d_n = ~crc[7:0];
      default:  en_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      pay_len         <= '0;
      ifg_len         <= '0;
      hdr             <= '0;
      crc             <= '1;
      run_cnt         <= '0;
      frame_lim       <= '0;
      armed           <= 1'b1;
      bus.gmii_d      <= '0;
      bus.gmii_en     <= 1'b0;
      bus.gmii_er     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.pkts_sent   <= '0;
      bus.octets_sent <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bus.gmii_d  <= d_n;
      bus.gmii_en <= en_n;
      bus.gmii_er <= 1'b0;
      bus.busy    <= (state_n != IDLE);

      if (en_n)
        bus.octets_sent <= bus.octets_sent + 64'd1;
      if (state_n == FCS && cnt_n == 16'd3) begin
        bus.pkts_sent <= bus.pkts_sent + 32'd1;
        run_cnt       <= run_cnt + 32'd1;
      end

      if (state == IDLE && !bus.enable)
        armed <= 1'b1;
      if (run_start) begin
        armed     <= 1'b0;
        run_cnt   <= '0;
        frame_lim <= bus.frame_count;
      end

      // Header and FCS leave through shift registers; the CRC register is
      // consumed byte-wise once the payload is done.
      if (start) begin
        pay_len <= eff_size - 16'd18;
        ifg_len <= eff_ifg;
        hdr     <= {bus.dst_mac, bus.src_mac, bus.ethertype};
        crc     <= '1;
      end else if (state_n == HEADER) begin
        hdr <= {hdr[103:0], 8'h00};
        crc <= crc_byte(crc, d_n);
      end else if (state_n == PAYLOAD) begin
        crc <= crc_byte(crc, d_n);
      end else if (state_n == FCS) begin
        crc <= {8'h00, crc[31:8]};
      end
    end
  end

endmodule

// File: tb/tb_traffic_generator_gmii.sv
// Scoreboard bench for traffic_generator_gmii: stimulus queues expected
// frames, a negedge monitor checks every frame and gap seen on GMII.
module tb_traffic_generator_gmii;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  traffic_generator_gmii_if bus();

  traffic_generator_gmii #(.C_MIN_IFG(12), .C_MAX_FRAME(1518)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int unsigned size;
    int unsigned ifg;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] et;
    bit          abort;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  bytes[$];
  int          checks = 0;
  int          failures = 0;
  longint unsigned tot_pkts = 0;
  longint unsigned tot_oct = 0;

  exp_t        cur;
  bit          have = 0, in_frame = 0, in_gap = 0;
  int unsigned gap_cnt = 0, gap_exp = 0;
  logic        er_seen = 1'b0;

  localparam logic [47:0] DA1 = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SA1 = 48'h000A35000001;
  localparam logic [47:0] DA2 = 48'h0123456789AB;
  localparam logic [47:0] SA2 = 48'h02AABBCCDDEE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_fwd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ b[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input exp_t r, input int unsigned i);
    logic [111:0] h;
    h = {r.da, r.sa, r.et};
    if (i < 7)  return 8'h55;
    if (i == 7) return 8'hD5;
    if (i < 22) return h[8*(21-i) +: 8];
    return 8'((i - 22) % 256);
  endfunction

  task automatic end_frame();
    int unsigned n, lim, idx;
    bit          found;
    logic [31:0] c;
    if (!have) return;
    n     = bytes.size();
    lim   = cur.abort ? n : ((n < cur.size + 4) ? n : cur.size + 4);
    found = 0;
    idx   = lim - 1;
    for (int unsigned i = 0; i < lim; i++)
      if (!found && bytes[i] !== exp_byte(cur, i)) begin found = 1; idx = i; end
    chk($sformatf("content_byte_%0d", idx), 64'(bytes[idx]), 64'(exp_byte(cur, idx)));
    if (cur.abort) begin
      tot_pkts = 0;
      tot_oct  = 0;
      return;
    end
    chk("frame_len", 64'(n), 64'(cur.size + 8));
    c = '1;
    for (int unsigned i = 8; i < n; i++) c = crc_fwd(c, bytes[i]);
    chk("fcs_residue", 64'(c), 64'h00000000C704DD7B);
    tot_pkts += 1;
    tot_oct  += 64'(cur.size + 8);
    chk("pkts_sent", 64'(bus.pkts_sent), tot_pkts);
    chk("octets_sent", bus.octets_sent, tot_oct);
    chk("gmii_er", 64'(er_seen), 64'd0);
    in_gap  = 1;
    gap_cnt = 0;
    gap_exp = cur.ifg;
  endtask

  always @(negedge clk) begin
    if (bus.gmii_en) begin
      if (!in_frame) begin
        if (in_gap) begin
          chk("gap_len", 64'(gap_cnt), 64'(gap_exp));
          in_gap = 0;
        end
        in_frame = 1;
        bytes.delete();
        er_seen = 1'b0;
        if (exp_q.size() == 0) begin
          have = 0;
          checks++;
          failures++;
          $display("FAIL unexpected_frame: frame started with none expected at %0t", $time);
        end else begin
          cur  = exp_q.pop_front();
          have = 1;
        end
      end
      bytes.push_back(bus.gmii_d);
      er_seen = er_seen | bus.gmii_er;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        end_frame();
      end
      if (in_gap) begin
        if (bus.busy) gap_cnt++;
        else begin
          chk("gap_len", 64'(gap_cnt), 64'(gap_exp));
          in_gap = 0;
        end
      end
    end
  end

  task automatic push(input int unsigned size, input int unsigned ifg,
                      input logic [47:0] da, input logic [47:0] sa,
                      input logic [15:0] et, input bit abort);
    exp_t e;
    e.size = size; e.ifg = ifg; e.da = da; e.sa = sa; e.et = et; e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input logic [15:0] fs, input logic [15:0] ifg, input logic [31:0] cnt,
                         input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et);
    bus.enable      = 1'b0;
    bus.frame_size  = fs;
    bus.ifg         = ifg;
    bus.frame_count = cnt;
    bus.dst_mac     = da;
    bus.src_mac     = sa;
    bus.ethertype   = et;
    @(posedge clk); #1;
  endtask

  task automatic wait_run(input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    while (!bus.busy && n < 4) begin @(posedge clk); #1; n++; end
    while (bus.busy && n < max_cyc) begin @(posedge clk); #1; n++; end
    chk("run_finished_busy", 64'(bus.busy), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    resetn = 1'b0;
    set_cfg(16'd64, 16'd12, 32'd1, DA1, SA1, 16'h0800);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gmii_en", 64'(bus.gmii_en), 64'd0);
    chk("rst_gmii_d", 64'(bus.gmii_d), 64'd0);
    chk("rst_gmii_er", 64'(bus.gmii_er), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pkts", 64'(bus.pkts_sent), 64'd0);
    chk("rst_octets", bus.octets_sent, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: single 64-byte frame, enable pulsed for one cycle
    set_cfg(16'd64, 16'd12, 32'd1, DA1, SA1, 16'h0800);
    push(64, 12, DA1, SA1, 16'h0800, 0);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    wait_run(200);
    chk("s1_pkts", 64'(bus.pkts_sent), 64'd1);
    chk("s1_octets", bus.octets_sent, 64'd72);

    // Scenario 2: clamped size and gap, two frames, enable held past the run
    set_cfg(16'd10, 16'd3, 32'd2, SA1, DA1, 16'h86DD);
    push(64, 12, SA1, DA1, 16'h86DD, 0);
    push(64, 12, SA1, DA1, 16'h86DD, 0);
    bus.enable = 1'b1;
    wait_run(400);
    repeat (5) begin @(posedge clk); #1; end
    chk("s2_no_rearm_busy", 64'(bus.busy), 64'd0);
    chk("s2_pkts", 64'(bus.pkts_sent), 64'd3);
    chk("s2_octets", bus.octets_sent, 64'd216);

    // Scenario 3: maximum frame, payload wraps past 0xFF
    set_cfg(16'd1518, 16'd12, 32'd1, DA2, SA2, 16'h88B5);
    push(1518, 12, DA2, SA2, 16'h88B5, 0);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    wait_run(2000);
    chk("s3_pkts", 64'(bus.pkts_sent), 64'd4);
    chk("s3_octets", bus.octets_sent, 64'd1742);

    // Scenario 4: unlimited run, enable dropped inside the 9th frame
    set_cfg(16'd100, 16'd12, 32'd0, DA2, SA1, 16'h0806);
    for (int i = 0; i < 9; i++) push(100, 12, DA2, SA1, 16'h0806, 0);
    bus.enable = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    wait_run(500);
    chk("s4_pkts", 64'(bus.pkts_sent), 64'd13);
    chk("s4_octets", bus.octets_sent, 64'd2714);

    // Scenario 5: reset at octet 30, restart immediately afterwards
    set_cfg(16'd64, 16'd12, 32'd1, DA1, SA2, 16'h0800);
    push(64, 12, DA1, SA2, 16'h0800, 1);
    push(64, 12, DA1, SA2, 16'h0800, 0);
    bus.enable = 1'b1;
    n = 0;
    while (!bus.gmii_en && n < 5) begin @(posedge clk); #1; n++; end
    chk("s5_frame_started", 64'(bus.gmii_en), 64'd1);
    repeat (29) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("s5_en_dropped", 64'(bus.gmii_en), 64'd0);
    chk("s5_pkts_cleared", 64'(bus.pkts_sent), 64'd0);
    chk("s5_octets_cleared", bus.octets_sent, 64'd0);
    chk("s5_busy_cleared", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("s5_restart_en", 64'(bus.gmii_en), 64'd1);
    chk("s5_restart_d", 64'(bus.gmii_d), 64'h55);
    wait_run(300);
    bus.enable = 1'b0;
    chk("s5_pkts", 64'(bus.pkts_sent), 64'd1);
    chk("s5_octets", bus.octets_sent, 64'd72);

    // Scenario 6: size and DA change mid-frame apply only to the next frame
    set_cfg(16'd64, 16'd12, 32'd2, DA1, SA1, 16'h0800);
    push(64, 12, DA1, SA1, 16'h0800, 0);
    push(100, 12, DA2, SA1, 16'h0800, 0);
    bus.enable = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    bus.frame_size = 16'd100;
    bus.dst_mac    = DA2;
    wait_run(500);
    bus.enable = 1'b0;
    chk("s6_pkts", 64'(bus.pkts_sent), 64'd3);
    chk("s6_octets", bus.octets_sent, 64'd252);

    repeat (5) begin @(posedge clk); #1; end
    chk("expected_frames_left", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
